// File: rtl/cpu_pkg.sv
// Shared CPU front-end constants and the fetch sequencer state type.
package cpu_pkg;

    localparam int unsigned PM_ADDR_W = 10;
    localparam int unsigned INST_W    = 32;
    localparam logic [31:0] HALT_INST = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_sequencer_pc_register.sv
// Program counter: synchronous load, increment and natural wrap at 2^W.
module pc_register #(
    parameter int unsigned W = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_addr_i,
    input  logic         inc_i,
    output logic [W-1:0] pc_o
);

    logic [W-1:0] pc_q, pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_addr_i;
        end else if (inc_i) begin
            pc_d = pc_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: launches program-memory reads from pc and
// delivers them over a valid/ready handshake with stall, redirect and halt.
module fetch_sequencer #(
    parameter int unsigned           PM_ADDR_W = cpu_pkg::PM_ADDR_W,
    parameter int unsigned           INST_W    = cpu_pkg::INST_W,
    parameter logic [INST_W-1:0]     HALT_INST = INST_W'(cpu_pkg::HALT_INST)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run,
    input  logic                 redirect,
    input  logic [PM_ADDR_W-1:0] redirect_addr,
    output logic [PM_ADDR_W-1:0] pm_addr,
    input  logic [INST_W-1:0]    pm_inst,
    output logic [INST_W-1:0]    inst,
    output logic [PM_ADDR_W-1:0] inst_pc,
    output logic                 inst_valid,
    input  logic                 inst_ready,
    output logic                 halted
);

    import cpu_pkg::*;

    fetch_state_e         state_q, state_d;
    logic                 pending_q, pending_d;
    logic [PM_ADDR_W-1:0] pending_pc_q, pending_pc_d;
    logic [INST_W-1:0]    hold_inst_q, hold_inst_d;
    logic [PM_ADDR_W-1:0] hold_pc_q, hold_pc_d;

    logic [PM_ADDR_W-1:0] pc;
    logic                 pc_load;
    logic                 pc_inc;
    logic                 launch;
    logic                 xfer;
    logic                 xfer_halt;

    pc_register #(
        .W (PM_ADDR_W)
    ) u_pc (
        .clk         (clk),
        .reset       (reset),
        .load_i      (pc_load),
        .load_addr_i (redirect_addr),
        .inc_i       (pc_inc),
        .pc_o        (pc)
    );

    assign pm_addr   = pc;
    assign xfer      = inst_valid && inst_ready;
    assign xfer_halt = xfer && (inst == HALT_INST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            pending_q    <= 1'b0;
            pending_pc_q <= '0;
            hold_inst_q  <= '0;
            hold_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            pending_pc_q <= pending_pc_d;
            hold_inst_q  <= hold_inst_d;
            hold_pc_q    <= hold_pc_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        pending_pc_d = pending_pc_q;
        hold_inst_d  = hold_inst_q;
        hold_pc_d    = hold_pc_q;
        launch       = 1'b0;
        pc_load      = 1'b0;
        pc_inc       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (pending_q && !inst_ready) begin
                    // Memory output only lasts one cycle: park it before it is overwritten.
                    hold_inst_d = pm_inst;
                    hold_pc_d   = pending_pc_q;
                    pending_d   = 1'b0;
                    state_d     = ST_HOLD;
                end else if (run) begin
                    launch = 1'b1;
                end else begin
                    pending_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (inst_ready) begin
                    if (run) begin
                        launch  = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
            end
        endcase

        if (launch) begin
            pending_d    = 1'b1;
            pending_pc_d = pc;
            pc_inc       = 1'b1;
        end

        // A delivered halt word beats a same-cycle redirect.
        if (xfer_halt) begin
            state_d   = ST_HALT;
            pending_d = 1'b0;
            pc_inc    = 1'b0;
        end else if (redirect && (state_q != ST_HALT)) begin
            state_d   = ST_FETCH;
            pending_d = 1'b0;
            pc_load   = 1'b1;
            pc_inc    = 1'b0;
        end
    end

    always_comb begin
        inst_valid = 1'b0;
        inst       = hold_inst_q;
        inst_pc    = hold_pc_q;
        halted     = 1'b0;
        case (state_q)
            ST_FETCH: begin
                inst_valid = pending_q;
                inst       = pm_inst;
                inst_pc    = pending_pc_q;
            end
            ST_HOLD: begin
                inst_valid = 1'b1;
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter PM_ADDR_W, default 10, program memory address width.
REQ-002 SHALL have parameter INST_W, default 32, instruction width.
REQ-003 SHALL have parameter HALT_INST, default 32'hFFFF_FFFF, instruction word that stops fetching.
REQ-004 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port run  input  1  enables launching of new fetches.
REQ-007 SHALL have port redirect  input  1  branch/jump request, one-cycle pulse.
REQ-008 SHALL have port redirect_addr  input  PM_ADDR_W  target address of redirect.
REQ-009 SHALL have port pm_addr  output  PM_ADDR_W  address to program_memory addr.
REQ-010 SHALL have port pm_inst  input  INST_W  data from program_memory inst, valid one cycle after pm_addr.
REQ-011 SHALL have port inst  output  INST_W  delivered instruction.
REQ-012 SHALL have port inst_pc  output  PM_ADDR_W  address of delivered instruction.
REQ-013 SHALL have port inst_valid  output  1  inst/inst_pc valid.
REQ-014 SHALL have port inst_ready  input  1  consumer accepts; transfer when inst_valid && inst_ready.
REQ-015 SHALL have port halted  output  1  high while in HALT.

Function
REQ-016 SHALL implement states IDLE, FETCH, HOLD, HALT, with pm_addr = pc register at all times.
REQ-017 SHALL "launch" a fetch by registering pending<=1, pending_pc<=pc, pc<=pc+1; pm_inst then belongs to pending_pc next cycle.
REQ-018 SHALL drive inst_valid = (FETCH && pending) || HOLD; inst = pm_inst, inst_pc = pending_pc in FETCH, else hold registers.
REQ-019 IDLE: no launch; run=1 moves to FETCH, first launch occurs in the first FETCH cycle.
REQ-020 FETCH: launch when run && (!pending || inst_ready); pending && !inst_ready captures pm_inst/pending_pc into hold registers, no launch, next state HOLD.
REQ-021 HOLD: inst_ready=1 launches (pc advances) and returns to FETCH with zero bubble; inst_ready=0 stays.
REQ-022 FETCH with run=0 SHALL finish delivering any pending instruction, then enter IDLE.
REQ-023 Redirect in IDLE/FETCH/HOLD SHALL set pc<=redirect_addr, clear pending, discard hold, enter FETCH; first target instruction valid 2 cycles after the redirect cycle.
REQ-024 A transfer in the redirect cycle SHALL complete normally; the redirect still squashes all later data.
REQ-025 A completed transfer of HALT_INST SHALL enter HALT regardless of simultaneous redirect.
REQ-026 HALT: inst_valid=0, halted=1, no launches, redirect and run ignored; exit only by reset.
REQ-027 pc SHALL wrap from 2^PM_ADDR_W-1 to 0 with no error indication.
REQ-028 No instruction SHALL be duplicated or dropped across stall/resume sequences.

Reset
REQ-029 Reset SHALL override all inputs and set state=IDLE, pc=0, pending=0, hold registers=0, inst_valid=0, halted=0, pm_addr=0.
REQ-030 Reset asserted mid-stall or mid-redirect SHALL discard all in-flight data; first post-reset instruction is address 0.

Structure
REQ-031 Shared package cpu_pkg SHALL hold PM_ADDR_W, INST_W, HALT_INST and the fetch state enum type.
REQ-032 pc register with load/increment/wrap SHALL be a sub-module pc_register; the remainder is a single module.

Verification (memory preloaded mem[n] = 32'h1111_1111*(n+1) for n=0..7, mem[8]=32'hFFFF_FFFF)
REQ-033 reset, run=1, inst_ready=1 -> inst_valid first high 2 cycles after run, inst_pc 0,1,2... one per cycle, inst 0x11111111, 0x22222222...
REQ-034 inst_ready=0 for 3 cycles while inst_pc=2 -> inst=0x33333333 held stable, then inst_pc 3 the cycle after ready returns.
REQ-035 redirect=1, redirect_addr=6 while inst_pc=1 -> inst_pc 1 transfers, next valid is inst_pc=6 inst=0x77777777 2 cycles later.
REQ-036 run to address 8 -> HALT_INST transferred, halted=1 next cycle, inst_valid stays 0 for 20 cycles despite redirect pulses.
REQ-037 redirect_addr=1023 with mem[1023]=0x0000ABCD -> inst_pc 1023 then inst_pc 0; reset during HOLD -> inst_valid=0 next cycle, restart at pc 0.
